// File: rtl/decode_execute_ctrl.sv
// Decode->Execute control register with condition check and NZCV flag register.
// Gated E-stage controls are qualified combinationally by the condition result.
module decode_execute_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic       RegWriteD,
  input  logic       MemToRegD,
  input  logic       MemWriteD,
  input  logic       BranchD,
  input  logic       PCSrcD,
  input  logic       PlusOneD,
  input  logic       ALUSrcD,
  input  logic [3:0] ALUControlD,
  input  logic [1:0] FlagWD,
  input  logic [3:0] CondD,
  input  logic [3:0] ALUFlagsE,
  output logic       ALUSrcE,
  output logic       MemToRegE,
  output logic       PlusOneE,
  output logic [3:0] ALUControlE,
  output logic       RegWriteGE,
  output logic       MemWriteGE,
  output logic       PCSrcGE,
  output logic       BranchTakenE,
  output logic       CondExE,
  output logic [3:0] FlagsE
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       pc_src;
    logic       plus_one;
    logic       alu_src;
    logic [3:0] alu_control;
    logic [1:0] flag_w;
    logic [3:0] cond;
  } ctrl_t;

  ctrl_t      e_d, e_q;
  logic [3:0] flags_d, flags_q;
  logic       cond_ex_s;

  // ARM condition evaluation against {N,Z,C,V}; 4'b1111 doubles as the bubble code
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: cond_check = z;
      4'b0001: cond_check = ~z;
      4'b0010: cond_check = c;
      4'b0011: cond_check = ~c;
      4'b0100: cond_check = n;
      4'b0101: cond_check = ~n;
      4'b0110: cond_check = v;
      4'b0111: cond_check = ~v;
      4'b1000: cond_check = c & ~z;
      4'b1001: cond_check = ~c | z;
      4'b1010: cond_check = (n == v);
      4'b1011: cond_check = (n != v);
      4'b1100: cond_check = ~z & (n == v);
      4'b1101: cond_check = z | (n != v);
      4'b1110: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

  assign cond_ex_s = cond_check(e_q.cond, flags_q);

  // E register next state: flush beats stall, stall beats load
  always_comb begin
    e_d = e_q;
    if (FlushE) begin
      e_d      = '0;
      e_d.cond = 4'b1111;
    end else if (StallE) begin
      e_d = e_q;
    end else begin
      e_d.reg_write   = RegWriteD;
      e_d.mem_to_reg  = MemToRegD;
      e_d.mem_write   = MemWriteD;
      e_d.branch      = BranchD;
      e_d.pc_src      = PCSrcD;
      e_d.plus_one    = PlusOneD;
      e_d.alu_src     = ALUSrcD;
      e_d.alu_control = ALUControlD;
      e_d.flag_w      = FlagWD;
      e_d.cond        = CondD;
    end
  end

  // Flags commit once, on the edge where a passing instruction leaves E
  always_comb begin
    flags_d = flags_q;
    if (cond_ex_s && !StallE) begin
      if (e_q.flag_w[1]) begin
        flags_d[3:2] = ALUFlagsE[3:2];
      end else begin
        flags_d[3:2] = flags_q[3:2];
      end
      if (e_q.flag_w[0]) begin
        flags_d[1:0] = ALUFlagsE[1:0];
      end else begin
        flags_d[1:0] = flags_q[1:0];
      end
    end else begin
      flags_d = flags_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q      <= '0;
      e_q.cond <= 4'b1111;
      flags_q  <= 4'b0000;
    end else begin
      e_q     <= e_d;
      flags_q <= flags_d;
    end
  end

  assign ALUSrcE      = e_q.alu_src;
  assign MemToRegE    = e_q.mem_to_reg;
  assign PlusOneE     = e_q.plus_one;
  assign ALUControlE  = e_q.alu_control;
  assign CondExE      = cond_ex_s;
  assign RegWriteGE   = e_q.reg_write & cond_ex_s;
  assign MemWriteGE   = e_q.mem_write & cond_ex_s;
  assign PCSrcGE      = e_q.pc_src & cond_ex_s;
  assign BranchTakenE = e_q.branch & cond_ex_s;
  assign FlagsE       = flags_q;

endmodule
